// File: rtl/depth_test.sv
// Z-buffer stage: read-compare-write of fragment depth against an external depth BRAM,
// forwarding passing fragments to the framebuffer write port, plus full-buffer sweep clear.
module depth_test #(
   parameter int unsigned WIDTH       = 320,
   parameter int unsigned HEIGHT      = 240,
   parameter int unsigned ADDR_W      = 17,
   parameter logic [31:0] DEPTH_CLEAR = 32'h7FFF_FFFF,
   parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       in_x,
   input  logic [15:0]       in_y,
   input  logic [11:0]       in_color,
   input  logic [31:0]       in_depth,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              zb_rd_en,
   output logic [ADDR_W-1:0] zb_rd_addr,
   input  logic [31:0]       zb_rd_data,
   output logic              zb_wr_en,
   output logic [ADDR_W-1:0] zb_wr_addr,
   output logic [31:0]       zb_wr_data,
   output logic              fb_wr_valid,
   input  logic              fb_wr_ready,
   output logic [ADDR_W-1:0] fb_wr_addr,
   output logic [11:0]       fb_wr_color,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_CLEAR} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [11:0]       color;
      logic [31:0]       depth;
   } frag_t;

   state_t state_q, state_d;
   logic   alive_q;

   // stage A: raw accepted fragment
   logic        a_vld_q, a_vld_d;
   logic [15:0] a_x_q, a_x_d, a_y_q, a_y_d;
   logic [11:0] a_color_q, a_color_d;
   logic [31:0] a_depth_q, a_depth_d;
   // stage B: read issue
   logic        b_vld_q, b_vld_d;
   frag_t       b_q, b_d;
   // stage H: read data return, held across stalls, plus forwarded late writes
   logic        h_vld_q, h_vld_d;
   frag_t       h_q, h_d;
   logic        h_fresh_q, h_fresh_d;
   logic [31:0] h_hold_q, h_hold_d;
   logic        h_fwd_vld_q, h_fwd_vld_d;
   logic [31:0] h_fwd_q, h_fwd_d;
   // stage C: passing fragment waiting on the framebuffer handshake
   logic        c_vld_q, c_vld_d;
   frag_t       c_q, c_d;

   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

   logic              a_drop, a_free, b_free, h_free, c_free;
   logic              accept, pipe_empty, clr_mode, h_pass;
   logic [ADDR_W-1:0] a_addr;
   logic [31:0]       h_rd, h_stored;
   frag_t             a_frag;

   // Range check on the full-width coordinates; only the final address is truncated.
   assign a_drop = ({16'd0, a_x_q} >= WIDTH) || ({16'd0, a_y_q} >= HEIGHT);
   assign a_addr = ADDR_W'({16'd0, a_y_q} * WIDTH + {16'd0, a_x_q});
   assign a_frag = '{addr: a_addr, color: a_color_q, depth: a_depth_q};

   assign c_free     = !c_vld_q || fb_wr_ready;
   assign h_free     = !h_vld_q || c_free;
   assign b_free     = !b_vld_q || h_free;
   assign a_free     = !a_vld_q || a_drop || b_free;
   assign accept     = in_valid && in_ready;
   assign pipe_empty = !(a_vld_q || b_vld_q || h_vld_q || c_vld_q);

   // Newest depth for the pixel: pending C entry, then a write seen since the read, then BRAM.
   assign h_rd     = h_fresh_q ? zb_rd_data : h_hold_q;
   assign h_stored = (c_vld_q && c_q.addr == h_q.addr) ? c_q.depth :
                     h_fwd_vld_q                       ? h_fwd_q   : h_rd;
   assign h_pass   = $signed(h_q.depth) < $signed(h_stored);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         alive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         alive_q <= 1'b1;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (clear_start)   state_d = S_CLEAR;
            else if (in_valid) state_d = S_RUN;
         end
         S_RUN: begin
            if (clear_start)                  state_d = S_DRAIN;
            else if (pipe_empty && !in_valid) state_d = S_IDLE;
         end
         S_DRAIN: if (pipe_empty) state_d = S_CLEAR;
         S_CLEAR: if (fb_wr_ready && clr_addr_q == LAST_ADDR) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      clr_mode    = (state_q == S_CLEAR);
      clear_busy  = (state_q == S_DRAIN) || clr_mode;
      // a fragment arriving with clear_start in IDLE is refused so the clear starts on an empty pipe
      in_ready    = alive_q && a_free &&
                    ((state_q == S_RUN) || (state_q == S_IDLE && !clear_start));
      busy        = !pipe_empty || (state_q != S_IDLE);
      fb_wr_valid = clr_mode ? 1'b1        : c_vld_q;
      fb_wr_addr  = clr_mode ? clr_addr_q  : c_q.addr;
      fb_wr_color = clr_mode ? CLEAR_COLOR : c_q.color;
      zb_wr_data  = clr_mode ? DEPTH_CLEAR : c_q.depth;
      zb_wr_en    = fb_wr_valid && fb_wr_ready;
      zb_wr_addr  = fb_wr_addr;
      zb_rd_en    = b_vld_q && h_free;
      zb_rd_addr  = b_q.addr;
   end

   // ---------------- datapath next state ----------------
   always_comb begin
      a_vld_d     = a_vld_q;
      a_x_d       = a_x_q;
      a_y_d       = a_y_q;
      a_color_d   = a_color_q;
      a_depth_d   = a_depth_q;
      b_vld_d     = b_vld_q;
      b_d         = b_q;
      h_vld_d     = h_vld_q;
      h_d         = h_q;
      h_fresh_d   = h_fresh_q;
      h_hold_d    = h_hold_q;
      h_fwd_vld_d = h_fwd_vld_q;
      h_fwd_d     = h_fwd_q;
      c_vld_d     = c_vld_q;
      c_d         = c_q;
      clr_addr_d  = clr_addr_q;

      if (a_free) begin
         a_vld_d = accept;
         if (accept) begin
            a_x_d     = in_x;
            a_y_d     = in_y;
            a_color_d = in_color;
            a_depth_d = in_depth;
         end
      end

      if (b_free) begin
         b_vld_d = a_vld_q && !a_drop;
         b_d     = a_frag;
      end

      // The read is issued in the cycle B moves into H, so it fires exactly once per fragment.
      if (h_free) begin
         h_vld_d     = b_vld_q;
         h_d         = b_q;
         h_fresh_d   = b_vld_q;
         h_fwd_vld_d = zb_wr_en && (zb_wr_addr == b_q.addr);
         h_fwd_d     = zb_wr_data;
      end else begin
         if (h_fresh_q) begin
            h_hold_d  = zb_rd_data;
            h_fresh_d = 1'b0;
         end
         if (zb_wr_en && zb_wr_addr == h_q.addr) begin
            h_fwd_vld_d = 1'b1;
            h_fwd_d     = zb_wr_data;
         end
      end

      if (c_free) begin
         c_vld_d = h_vld_q && h_pass;
         c_d     = h_q;
      end

      if (clr_mode && fb_wr_ready)
         clr_addr_d = (clr_addr_q == LAST_ADDR) ? '0 : clr_addr_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_vld_q     <= 1'b0;
         a_x_q       <= '0;
         a_y_q       <= '0;
         a_color_q   <= '0;
         a_depth_q   <= '0;
         b_vld_q     <= 1'b0;
         b_q         <= '0;
         h_vld_q     <= 1'b0;
         h_q         <= '0;
         h_fresh_q   <= 1'b0;
         h_hold_q    <= '0;
         h_fwd_vld_q <= 1'b0;
         h_fwd_q     <= '0;
         c_vld_q     <= 1'b0;
         c_q         <= '0;
         clr_addr_q  <= '0;
      end else begin
         a_vld_q     <= a_vld_d;
         a_x_q       <= a_x_d;
         a_y_q       <= a_y_d;
         a_color_q   <= a_color_d;
         a_depth_q   <= a_depth_d;
         b_vld_q     <= b_vld_d;
         b_q         <= b_d;
         h_vld_q     <= h_vld_d;
         h_q         <= h_d;
         h_fresh_q   <= h_fresh_d;
         h_hold_q    <= h_hold_d;
         h_fwd_vld_q <= h_fwd_vld_d;
         h_fwd_q     <= h_fwd_d;
         c_vld_q     <= c_vld_d;
         c_q         <= c_d;
         clr_addr_q  <= clr_addr_d;
      end
   end

endmodule

// File: tb/tb_depth_test.sv
// Directed bench for depth_test: behavioural depth BRAM plus framebuffer handshake monitor.
module tb_depth_test;

   localparam int          N  = 76800;
   localparam logic [31:0] DC = 32'h7FFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] in_x = '0, in_y = '0;
   logic [11:0] in_color = '0;
   logic [31:0] in_depth = '0;
   logic        in_valid = 1'b0, in_ready;
   logic        clear_start = 1'b0, clear_busy;
   logic        zb_rd_en, zb_wr_en;
   logic [16:0] zb_rd_addr, zb_wr_addr, fb_wr_addr;
   logic [31:0] zb_rd_data, zb_wr_data;
   logic        fb_wr_valid, fb_wr_ready = 1'b1, busy;
   logic [11:0] fb_wr_color;

   always #5 clk = ~clk;

   depth_test dut (
      .clk(clk), .rst(rst),
      .in_x(in_x), .in_y(in_y), .in_color(in_color), .in_depth(in_depth),
      .in_valid(in_valid), .in_ready(in_ready),
      .clear_start(clear_start), .clear_busy(clear_busy),
      .zb_rd_en(zb_rd_en), .zb_rd_addr(zb_rd_addr), .zb_rd_data(zb_rd_data),
      .zb_wr_en(zb_wr_en), .zb_wr_addr(zb_wr_addr), .zb_wr_data(zb_wr_data),
      .fb_wr_valid(fb_wr_valid), .fb_wr_ready(fb_wr_ready),
      .fb_wr_addr(fb_wr_addr), .fb_wr_color(fb_wr_color), .busy(busy)
   );

   // Depth BRAM (read-first, 1-cycle read latency) and handshake monitor.
   logic [31:0] mem [0:N-1] = '{default: 32'h0};
   int rd_cnt = 0, rd_in_clr = 0, frag_cnt = 0, frag_bad = 0;
   int clr_cnt = 0, clr_bad = 0, clr_exp = 0;
   int frag_log [$];

   always @(posedge clk) begin
      if (rst) clr_exp = 0;
      if (zb_rd_en) begin
         rd_cnt++;
         if (fb_wr_valid && fb_wr_color == 12'h000) rd_in_clr++;
         zb_rd_data <= mem[zb_rd_addr];
      end
      if (zb_wr_en) mem[zb_wr_addr] <= zb_wr_data;
      if (fb_wr_valid && fb_wr_ready) begin
         if (fb_wr_color == 12'h000) begin
            clr_cnt++;
            if (!zb_wr_en || zb_wr_data !== DC || 32'(fb_wr_addr) != clr_exp) clr_bad++;
            clr_exp = (clr_exp == N - 1) ? 0 : clr_exp + 1;
         end else begin
            frag_cnt++;
            frag_log.push_back(32'(fb_wr_addr));
            if (!zb_wr_en || zb_wr_addr !== fb_wr_addr || zb_wr_data !== dut.c_q.depth) frag_bad++;
         end
      end
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Presents one fragment for a single accepting edge; caller deasserts in_valid.
   task automatic put(input int x, input int y, input logic [11:0] c, input logic [31:0] d);
      @(negedge clk);
      chk("in_ready_before_put", 32'(in_ready), 32'd1);
      in_x = 16'(x); in_y = 16'(y); in_color = c; in_depth = d; in_valid = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      int f0, c0, r0, l0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready",    32'(in_ready),    32'd0);
      chk("rst_fb_wr_valid", 32'(fb_wr_valid), 32'd0);
      chk("rst_zb_rd_en",    32'(zb_rd_en),    32'd0);
      chk("rst_zb_wr_en",    32'(zb_wr_en),    32'd0);
      chk("rst_busy",        32'(busy),        32'd0);
      chk("rst_clear_busy",  32'(clear_busy),  32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // two fragments in flight, then clear request: both retire, then full sweep
      f0 = frag_cnt; c0 = clr_cnt;
      put(1, 1, 12'hABC, 32'hFFFF_FFFF);
      put(2, 1, 12'hABD, 32'hFFFF_FFFF);
      @(negedge clk);
      in_valid = 1'b0; clear_start = 1'b1;
      @(posedge clk); #1;
      clear_start = 1'b0;
      chk("drain_clear_busy", 32'(clear_busy), 32'd1);
      chk("drain_in_ready",   32'(in_ready),   32'd0);
      for (int i = 0; i < 80000 && clear_busy; i++) @(negedge clk);
      chk("clear_done",       32'(clear_busy),     32'd0);
      chk("drain_frag_writes", 32'(frag_cnt - f0), 32'd2);
      chk("clear_writes",     32'(clr_cnt - c0),   32'd76800);
      chk("clear_bad_writes", 32'(clr_bad),        32'd0);
      chk("clear_reads",      32'(rd_in_clr),      32'd0);
      chk("clear_mem_321",    mem[321],            DC);
      chk("clear_idle_busy",  32'(busy),           32'd0);

      // single fragment latency: (10,5) -> addr 1610
      r0 = rd_cnt;
      put(10, 5, 12'hF00, 32'h0001_0000);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("t1_rd_en",    32'(zb_rd_en),   32'd1);
      chk("t1_rd_addr",  32'(zb_rd_addr), 32'd1610);
      @(posedge clk); #1;
      chk("t1_rd_once",  32'(zb_rd_en),   32'd0);
      chk("t1_fb_early", 32'(fb_wr_valid), 32'd0);
      @(posedge clk); #1;
      chk("t1_fb_valid", 32'(fb_wr_valid), 32'd1);
      chk("t1_fb_addr",  32'(fb_wr_addr),  32'd1610);
      chk("t1_fb_color", 32'(fb_wr_color), 32'hF00);
      chk("t1_zb_wr_en", 32'(zb_wr_en),    32'd1);
      chk("t1_zb_data",  zb_wr_data,       32'h0001_0000);
      @(posedge clk); #1;
      chk("t1_fb_done",  32'(fb_wr_valid), 32'd0);
      chk("t1_mem",      mem[1610],        32'h0001_0000);
      chk("t1_rd_count", 32'(rd_cnt - r0), 32'd1);

      // same pixel back-to-back, decreasing depth: both pass (addr 7*320+20 = 2260)
      f0 = frag_cnt;
      put(20, 7, 12'h111, 32'h0002_0000);
      put(20, 7, 12'h222, 32'h0000_8000);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("t2_writes", 32'(frag_cnt - f0), 32'd2);
      chk("t2_mem",    mem[2260],          32'h0000_8000);

      // same pixel back-to-back tie: second fails (addr 8*320+30 = 2590)
      f0 = frag_cnt;
      put(30, 8, 12'h333, 32'h0000_8000);
      put(30, 8, 12'h444, 32'h0000_8000);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("t3_writes", 32'(frag_cnt - f0), 32'd1);
      chk("t3_mem",    mem[2590],          32'h0000_8000);

      // tie with one idle cycle: earlier commit lands in the read cycle (addr 2610)
      f0 = frag_cnt;
      put(50, 8, 12'h555, 32'h0000_8000);
      in_valid = 1'b0;
      @(posedge clk);
      put(50, 8, 12'h666, 32'h0000_8000);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("t3b_writes", 32'(frag_cnt - f0), 32'd1);

      // negative depth beats a positive stored value, larger depth fails (addr 2611)
      f0 = frag_cnt;
      put(51, 8, 12'h777, 32'hFFFF_0000);
      put(51, 8, 12'h888, 32'h0000_0001);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("t3c_writes", 32'(frag_cnt - f0), 32'd1);
      chk("t3c_mem",    mem[2611],          32'hFFFF_0000);

      // out-of-range fragments are dropped
      f0 = frag_cnt; r0 = rd_cnt;
      put(320, 0, 12'h999, 32'h0);
      put(0, 240, 12'h999, 32'h0);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("t4_reads",    32'(rd_cnt - r0),   32'd0);
      chk("t4_writes",   32'(frag_cnt - f0), 32'd0);
      chk("t4_in_ready", 32'(in_ready),      32'd1);

      // backpressure: four queued fragments fill the pipe, head held stable
      @(negedge clk);
      fb_wr_ready = 1'b0;
      f0 = frag_cnt; l0 = frag_log.size();
      put(40, 9, 12'h001, 32'h0000_1000);
      put(41, 9, 12'h002, 32'h0000_1000);
      put(42, 9, 12'h003, 32'h0000_1000);
      put(43, 9, 12'h004, 32'h0000_1000);
      in_valid = 1'b0;
      @(negedge clk);
      chk("t5_in_ready_low", 32'(in_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_hold_valid", 32'(fb_wr_valid), 32'd1);
         chk("t5_hold_addr",  32'(fb_wr_addr),  32'd2920);
         chk("t5_hold_color", 32'(fb_wr_color), 32'h001);
      end
      fb_wr_ready = 1'b1;
      repeat (10) @(negedge clk);
      chk("t5_writes", 32'(frag_cnt - f0), 32'd4);
      for (int i = 0; i < 4; i++)
         if (frag_log.size() > l0 + i)
            chk("t5_order", 32'(frag_log[l0 + i]), 32'(2920 + i));
      chk("frag_write_pairing", 32'(frag_bad), 32'd0);

      // reset mid-clear aborts immediately
      @(negedge clk);
      clear_start = 1'b1;
      @(posedge clk); #1;
      clear_start = 1'b0;
      repeat (50) @(negedge clk);
      chk("t6_mid_clear_busy", 32'(clear_busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("t6_rst_fb_valid", 32'(fb_wr_valid), 32'd0);
      chk("t6_rst_fb_addr",  32'(fb_wr_addr),  32'd0);
      chk("t6_rst_zb_wr_en", 32'(zb_wr_en),    32'd0);
      chk("t6_rst_zb_data",  zb_wr_data,       32'd0);
      chk("t6_rst_clr_busy", 32'(clear_busy),  32'd0);
      chk("t6_rst_busy",     32'(busy),        32'd0);
      chk("t6_rst_in_ready", 32'(in_ready),    32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("t6_idle_busy",     32'(busy),        32'd0);
      chk("t6_idle_fb_valid", 32'(fb_wr_valid), 32'd0);
      chk("t6_idle_in_ready", 32'(in_ready),    32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
